// File: rtl/osd_stm_mor1kx_tracebuf.sv
// Software-trace event extractor for the mor1kx trace port: catches l.nop trace events, pairs them
// with a shadow of the value register, and buffers them in a FWFT FIFO with overflow reporting.
module osd_stm_mor1kx_tracebuf #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned XLEN       = 64,
    parameter int unsigned DEPTH      = 4,
    parameter logic [4:0]  VALUE_REG  = 5'd3,
    parameter logic [15:0] NOP_PREFIX = 16'h1500,
    parameter logic [15:0] OVF_ID     = 16'hFFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    trace_valid_in,
    input  logic [31:0]             trace_insn,
    input  logic                    trace_wben,
    input  logic [4:0]              trace_wbreg,
    input  logic [DATA_WIDTH-1:0]   trace_wbdata,
    output logic                    trace_valid,
    input  logic                    trace_ready,
    output logic [15:0]             trace_id,
    output logic [XLEN-1:0]         trace_value,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [15:0]             lost_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef struct packed {
        logic [15:0]     id;
        logic [XLEN-1:0] value;
    } entry_t;

    logic [DATA_WIDTH-1:0] shadow;
    entry_t                mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [LW-1:0]         level;
    logic [15:0]           lost;

    logic                  event_hit;
    logic                  pop;
    logic                  space;
    logic [16:0]           lost_sum;
    logic [15:0]           lost_sat;
    logic                  push;
    entry_t                push_entry;
    logic [15:0]           lost_next;
    entry_t                head;

    assign event_hit = enable && trace_valid_in
                    && (trace_insn[31:16] == NOP_PREFIX)
                    && (trace_insn[15:0] != 16'h0000);

    assign pop   = trace_valid && trace_ready;
    assign space = (level < DEPTH_L) || pop;

    // Pending drops plus this cycle's event; the same saturated sum serves both the
    // overflow record and the drop counter, since a drop only happens with event_hit set.
    assign lost_sum = {1'b0, lost} + 17'(event_hit);
    assign lost_sat = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];

    // NOTE: every signal gets a default before the priority chain, so no latch is inferred.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        lost_next  = lost;
        if ((lost != 16'h0000) && space) begin
            push             = 1'b1;
            push_entry.id    = OVF_ID;
            push_entry.value = XLEN'(lost_sat);
            lost_next        = 16'h0000;
        end else if (event_hit && space) begin
            push             = 1'b1;
            push_entry.id    = trace_insn[15:0];
            push_entry.value = XLEN'(shadow);
        end else if (event_hit) begin
            lost_next = lost_sat;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values;
    // this is what keeps a same-cycle writeback invisible to the event captured alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            lost   <= '0;
        end else begin
            if (trace_wben && (trace_wbreg == VALUE_REG))
                shadow <= trace_wbdata;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            lost <= lost_next;
        end
    end

    // NOTE: storage is left unreset; outputs are masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    assign head        = mem[rd_ptr];
    assign trace_valid = (level != '0);
    assign trace_id    = trace_valid ? head.id : 16'h0000;
    assign trace_value = trace_valid ? head.value : '0;
    assign fifo_level  = level;
    assign lost_count  = lost;

endmodule

// File: tb/tb_osd_stm_mor1kx_tracebuf.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a queue-based model of the trace buffer.
module tb_osd_stm_mor1kx_tracebuf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        trace_valid_in;
    logic [31:0] trace_insn;
    logic        trace_wben;
    logic [4:0]  trace_wbreg;
    logic [31:0] trace_wbdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [15:0] trace_id;
    logic [63:0] trace_value;
    logic [2:0]  fifo_level;
    logic [15:0] lost_count;

    always #5 clk = ~clk;

    osd_stm_mor1kx_tracebuf #(
        .DATA_WIDTH(32), .XLEN(64), .DEPTH(DEPTH),
        .VALUE_REG(5'd3), .NOP_PREFIX(16'h1500), .OVF_ID(16'hFFFF)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .trace_valid_in(trace_valid_in),
        .trace_insn(trace_insn), .trace_wben(trace_wben), .trace_wbreg(trace_wbreg),
        .trace_wbdata(trace_wbdata), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_id(trace_id), .trace_value(trace_value), .fifo_level(fifo_level),
        .lost_count(lost_count)
    );

    typedef struct {
        logic [15:0] id;
        logic [63:0] value;
    } entry_t;

    entry_t      m_q[$];
    int unsigned m_lost;
    logic [31:0] m_shadow;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one clock edge of the trace buffer, from current inputs.
    task automatic model_step();
        bit     ev;
        bit     pop;
        bit     space;
        entry_t e;
        if (rst) begin
            m_q.delete();
            m_lost   = 0;
            m_shadow = '0;
            return;
        end
        ev    = enable && trace_valid_in && trace_insn[31:16] == 16'h1500 && trace_insn[15:0] != 0;
        pop   = (m_q.size() != 0) && trace_ready;
        space = (m_q.size() < DEPTH) || pop;
        if (pop) void'(m_q.pop_front());
        if (m_lost != 0 && space) begin
            e.id    = 16'hFFFF;
            e.value = (m_lost + ev > 65535) ? 64'd65535 : 64'(m_lost + ev);
            m_q.push_back(e);
            m_lost = 0;
        end else if (ev && space) begin
            e.id    = trace_insn[15:0];
            e.value = {32'h0, m_shadow};
            m_q.push_back(e);
        end else if (ev) begin
            m_lost = (m_lost + 1 > 65535) ? 65535 : m_lost + 1;
        end
        if (trace_wben && trace_wbreg == 5'd3) m_shadow = trace_wbdata;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("valid", 64'(trace_valid), 64'(m_q.size() != 0));
            check("level", 64'(fifo_level), 64'(m_q.size()));
            check("lost", 64'(lost_count), 64'(m_lost));
            check("id", 64'(trace_id), (m_q.size() != 0) ? 64'(m_q[0].id) : 64'h0);
            check("value", trace_value, (m_q.size() != 0) ? m_q[0].value : 64'h0);
        end
    end

    task automatic step(input bit r, input bit en, input bit vin, input logic [31:0] insn,
                        input bit wben, input logic [4:0] wreg, input logic [31:0] wdata,
                        input bit rdy);
        rst            = r;
        enable         = en;
        trace_valid_in = vin;
        trace_insn     = insn;
        trace_wben     = wben;
        trace_wbreg    = wreg;
        trace_wbdata   = wdata;
        trace_ready    = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic ev(input logic [15:0] id, input bit rdy);
        step(1'b0, 1'b1, 1'b1, {16'h1500, id}, 1'b0, 5'd0, 32'h0, rdy);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, rdy);
    endtask

    initial begin
        logic [15:0] rid;
        logic [31:0] rinsn;
        int          ready_pct;

        // Scenario 1: basic capture with shadow value
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        checking = 1'b1;
        check("rst_valid", 64'(trace_valid), 64'h0);
        check("rst_level", 64'(fifo_level), 64'h0);
        check("rst_lost", 64'(lost_count), 64'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1);
        ev(16'h0007, 1'b1);
        check("t1_valid", 64'(trace_valid), 64'h1);
        check("t1_id", 64'(trace_id), 64'h0007);
        check("t1_value", trace_value, 64'h00000000DEADBEEF);
        check("t1_level", 64'(fifo_level), 64'h1);
        idle(1'b1);
        check("t1_drained", 64'(fifo_level), 64'h0);

        // Scenario 2: same-cycle writeback is not seen by the event
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h15000002, 1'b1, 5'd3, 32'h1, 1'b0);
        check("t2_id", 64'(trace_id), 64'h0002);
        check("t2_value", trace_value, 64'h0);
        idle(1'b1);
        ev(16'h0009, 1'b0);
        check("t2_next_value", trace_value, 64'h1);
        idle(1'b1);

        // Scenario 3: non-events
        step(1'b0, 1'b1, 1'b1, 32'h15000000, 1'b0, 5'd0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h15010005, 1'b0, 5'd0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h15000003, 1'b0, 5'd0, 32'h0, 1'b1);
        check("t3_level", 64'(fifo_level), 64'h0);
        check("t3_valid", 64'(trace_valid), 64'h0);

        // Scenario 4: overflow with backpressure, then ordered drain
        for (int k = 1; k <= 7; k++) ev(16'(k), 1'b0);
        check("t4_level", 64'(fifo_level), 64'h4);
        check("t4_lost", 64'(lost_count), 64'h3);
        check("t4_head", 64'(trace_id), 64'h1);
        for (int k = 2; k <= 4; k++) begin
            idle(1'b1);
            check("t4_order", 64'(trace_id), 64'(k));
        end
        idle(1'b1);
        check("t4_ovf_id", 64'(trace_id), 64'hFFFF);
        check("t4_ovf_value", trace_value, 64'h3);
        check("t4_ovf_lost", 64'(lost_count), 64'h0);
        idle(1'b1);
        check("t4_empty", 64'(fifo_level), 64'h0);

        // Scenario 5: full FIFO, pop and push in the same cycle
        for (int k = 0; k < 4; k++) ev(16'h0010 + 16'(k), 1'b0);
        ev(16'h0014, 1'b1);
        check("t5_level", 64'(fifo_level), 64'h4);
        check("t5_lost", 64'(lost_count), 64'h0);
        check("t5_head", 64'(trace_id), 64'h0011);

        // Scenario 6: pending loss merged with a same-cycle event, then reset mid-stream
        ev(16'h0020, 1'b0);
        ev(16'h0021, 1'b0);
        check("t6_lost2", 64'(lost_count), 64'h2);
        ev(16'h0022, 1'b1);
        check("t6_lost0", 64'(lost_count), 64'h0);
        check("t6_level", 64'(fifo_level), 64'h4);
        idle(1'b1);
        check("t6_level3", 64'(fifo_level), 64'h3);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        check("t6_rst_valid", 64'(trace_valid), 64'h0);
        check("t6_rst_level", 64'(fifo_level), 64'h0);
        check("t6_rst_lost", 64'(lost_count), 64'h0);

        // Randomized traffic with phases of varying backpressure
        for (int i = 0; i < 4000; i++) begin
            case ((i / 200) % 3)
                0:       ready_pct = 10;
                1:       ready_pct = 50;
                default: ready_pct = 90;
            endcase
            case ($urandom_range(0, 19))
                0:       rid = 16'h0000;
                1:       rid = 16'hFFFF;
                default: rid = 16'($urandom);
            endcase
            rinsn = ($urandom_range(0, 9) < 7) ? {16'h1500, rid} : $urandom;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) != 0,
                 rinsn,
                 1'($urandom),
                 5'($urandom_range(0, 7)),
                 $urandom,
                 $urandom_range(0, 99) < ready_pct);
        end
        for (int i = 0; i < 10; i++) idle(1'b1);
        check("final_empty", 64'(fifo_level), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
